// File: rtl/writeback_arbiter_if.sv
// Register-file write-side bundle: ALU and slow-path producers in,
// single write port, hazard scoreboard and status flags out.
interface writeback_arbiter_if #(
    parameter int DWIDTH = 32
);
    logic              alu_valid_i;
    logic [4:0]        alu_rd_i;
    logic [DWIDTH-1:0] alu_data_i;
    logic              lsu_valid_i;
    logic              lsu_ready_o;
    logic [4:0]        lsu_rd_i;
    logic [DWIDTH-1:0] lsu_data_i;
    logic [4:0]        rd_o;
    logic [DWIDTH-1:0] datawb_o;
    logic              regwren_o;
    logic [31:0]       pending_o;
    logic              alu_stall_o;
    logic              full_o;
    logic              empty_o;
    logic              err_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  lsu_ready_o, rd_o, datawb_o, regwren_o,
        input  pending_o, alu_stall_o, full_o, empty_o, err_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output lsu_ready_o, rd_o, datawb_o, regwren_o,
        output pending_o, alu_stall_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the ALU result path with a buffered slow (LSU/MUL) path onto one registered
// register-file write. Define WB_BYPASS_EN to let slow results skip an empty FIFO.
module writeback_arbiter #(
    parameter int DWIDTH       = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    writeback_arbiter_if.slave  wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]        fifo_rd   [DEPTH];
    logic [DWIDTH-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0]  fifo_vld;
    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;
    logic              stall_q, err_q, wren_q;
    logic [4:0]        rd_q;
    logic [DWIDTH-1:0] data_q;

    logic full, empty, alu_req, lsu_acc;
    logic take_alu, pop, push, bypass, starve_hit;
    logic [31:0] pending;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign alu_req = wb.alu_valid_i && (wb.alu_rd_i != 5'd0);
    assign lsu_acc = wb.lsu_valid_i && !full && (wb.lsu_rd_i != 5'd0);

    // A forced-drain cycle always pops; otherwise ALU has priority over the FIFO head.
    always_comb begin
        take_alu = 1'b0;
        pop      = 1'b0;
        bypass   = 1'b0;
        if (stall_q && !empty) begin
            pop = 1'b1;
        end else if (alu_req && !stall_q) begin
            take_alu = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
`ifdef WB_BYPASS_EN
        bypass = lsu_acc && empty && !take_alu;
`else
        bypass = 1'b0;
`endif
        push = lsu_acc && !bypass;
    end

    assign starve_hit = take_alu && !empty && (starve_cnt == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            if (push) begin
                fifo_vld[wptr] <= 1'b1;
                wptr           <= wptr + 1'b1;
            end
            if (pop) begin
                fifo_vld[rptr] <= 1'b0;
                rptr           <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= wb.lsu_rd_i;
            fifo_data[wptr] <= wb.lsu_data_i;
        end
    end

    // Starvation only accrues while buffered work waits behind ALU wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            stall_q <= starve_hit;
            if (pop || empty || starve_hit) begin
                starve_cnt <= '0;
            end else if (take_alu) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (alu_req && stall_q) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
        end else if (take_alu) begin
            rd_q   <= wb.alu_rd_i;
            data_q <= wb.alu_data_i;
            wren_q <= 1'b1;
        end else if (pop) begin
            rd_q   <= fifo_rd[rptr];
            data_q <= fifo_data[rptr];
            wren_q <= 1'b1;
        end else if (bypass) begin
            rd_q   <= wb.lsu_rd_i;
            data_q <= wb.lsu_data_i;
            wren_q <= 1'b1;
        end else begin
            wren_q <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i]) begin
                pending[fifo_rd[i]] = 1'b1;
            end
        end
    end

    assign wb.lsu_ready_o = !full;
    assign wb.rd_o        = rd_q;
    assign wb.datawb_o    = data_q;
    assign wb.regwren_o   = wren_q;
    assign wb.pending_o   = pending;
    assign wb.alu_stall_o = stall_q;
    assign wb.full_o      = full;
    assign wb.empty_o     = empty;
    assign wb.err_o       = err_q;
endmodule
